// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 4-digit 7-segment display among N_REQ
// requesters. Grants rotate round robin and each one is held for exactly
// DWELL cycles so the shown value stays readable.
// Optional build macro SEG_ARB_PREEMPT_EN makes requester 0 urgent: it
// takes the display mid-dwell from any other owner.
module seg_display_arbiter #(
  parameter int          N_REQ      = 3,
  parameter int          DWELL      = 10_000_000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   value_flat,
  output logic [15:0]           disp_value,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  dwell_done
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_SHOW = 1'b1;
  localparam logic [23:0] RELOAD  = 24'(DWELL - 1);
  localparam logic [1:0]  RR_INIT = 2'(N_REQ - 1);

  // Reject out-of-range parameters while elaborating.
  generate
    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
      $error("seg_display_arbiter: N_REQ must be in 2..4");
    end
    if (DWELL < 2 || DWELL > 24'hFFFFFF) begin : g_bad_dwell
      $error("seg_display_arbiter: DWELL must be in 2..2^24-1");
    end
  endgenerate

  logic [0:0]  state;
  logic [23:0] cnt;
  logic [1:0]  rr;
  logic [1:0]  owner;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [15:0] value_of(input logic [16*N_REQ-1:0] vals,
                                           input logic [1:0] idx);
    value_of = vals[16*idx +: 16];
  endfunction

  // Round-robin pick: scan rr+1, rr+2, ... and keep the nearest active request.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = 2'((int'(rr) + k) % N_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Grant FSM with dwell counter; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 24'd0;
      rr         <= RR_INIT;
      owner      <= 2'd0;
      grant      <= '0;
      busy       <= 1'b0;
      dwell_done <= 1'b0;
      disp_value <= IDLE_VALUE;
    end else begin
      dwell_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_SHOW;
            owner      <= pick_idx;
            rr         <= pick_idx;
            grant      <= onehot(pick_idx);
            busy       <= 1'b1;
            cnt        <= RELOAD;
            disp_value <= value_of(value_flat, pick_idx);
          end
        end
        default: begin
`ifdef SEG_ARB_PREEMPT_EN
          if (owner != 2'd0 && req[0]) begin
            owner      <= 2'd0;
            grant      <= onehot(2'd0);
            cnt        <= RELOAD;
            disp_value <= value_of(value_flat, 2'd0);
          end else
`endif
          if (cnt != 24'd0) begin
            cnt <= cnt - 24'd1;
            if (cnt == 24'd1) dwell_done <= 1'b1;
            if (req[owner]) disp_value <= value_of(value_flat, owner);
          end else if (pick_valid) begin
            owner      <= pick_idx;
            rr         <= pick_idx;
            grant      <= onehot(pick_idx);
            cnt        <= RELOAD;
            disp_value <= value_of(value_flat, pick_idx);
          end else begin
            state      <= ST_IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            disp_value <= IDLE_VALUE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter with DWELL=4, N_REQ=3.
// Every driven cycle pushes the expected registered outputs onto a queue;
// after the following clock edge the entry is popped and compared.
// Directed checks at the interesting points of each scenario sit on top.
module tb_seg_display_arbiter;

  localparam int DW = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] value_flat;
  logic [15:0] disp_value;
  logic [2:0]  grant;
  logic        busy;
  logic        dwell_done;

  typedef struct packed {
    logic [15:0] disp;
    logic [2:0]  grant;
    logic        busy;
    logic        done;
  } outs_t;

  outs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should be after the next edge.
  logic        m_show;
  int          m_cnt;
  logic [1:0]  m_rr;
  logic [1:0]  m_owner;
  logic [15:0] m_disp;
  logic [2:0]  m_grant;
  logic        m_done;

  logic [47:0] vals;
  int          done_count;

  seg_display_arbiter #(
    .N_REQ(3),
    .DWELL(DW),
    .IDLE_VALUE(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .value_flat(value_flat),
    .disp_value(disp_value),
    .grant(grant),
    .busy(busy),
    .dwell_done(dwell_done)
  );

  // 100 MHz style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Round-robin choice as the model sees it; -1 when nobody asks.
  function automatic int rrPick(input logic [1:0] rr, input logic [2:0] rq);
    logic [1:0] c;
    for (int k = 1; k <= 3; k++) begin
      c = 2'((int'(rr) + k) % 3);
      if (rq[c]) return int'(c);
    end
    return -1;
  endfunction

  // Starts a fresh dwell for requester p in the model.
  task automatic modelGrant(input int p, input logic [47:0] v, input logic upd_rr);
    m_show  = 1'b1;
    m_owner = 2'(p);
    if (upd_rr) m_rr = 2'(p);
    m_grant = 3'b001 << p;
    m_cnt   = DW - 1;
    m_disp  = v[16*p +: 16];
  endtask

  // Advances the model by one clock edge given the inputs seen at that edge.
  task automatic modelStep(input logic r, input logic [2:0] rq, input logic [47:0] v);
    int p;
    if (r) begin
      m_show = 1'b0; m_cnt = 0; m_rr = 2'd2; m_owner = 2'd0;
      m_disp = 16'h0000; m_grant = 3'b000; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_show) begin
        p = rrPick(m_rr, rq);
        if (p >= 0) modelGrant(p, v, 1'b1);
      end
`ifdef SEG_ARB_PREEMPT_EN
      else if (m_owner != 2'd0 && rq[0]) begin
        modelGrant(0, v, 1'b0);
      end
`endif
      else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_done = 1'b1;
        if (rq[m_owner]) m_disp = v[16*m_owner +: 16];
      end else begin
        p = rrPick(m_rr, rq);
        if (p >= 0) modelGrant(p, v, 1'b1);
        else begin
          m_show = 1'b0; m_grant = 3'b000; m_disp = 16'h0000;
        end
      end
    end
  endtask

  // Drives one cycle of inputs, queues the expectation, then checks after the edge.
  task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [47:0] v);
    outs_t e;
    rst = r;
    req = rq;
    value_flat = v;
    modelStep(r, rq, v);
    exp_q.push_back('{disp: m_disp, grant: m_grant, busy: m_show, done: m_done});
    @(posedge clk);
    #1;
    if (dwell_done === 1'b1) done_count++;
    e = exp_q.pop_front();
    checkOutput("sb_disp", 32'(disp_value), 32'(e.disp));
    checkOutput("sb_grant", 32'(grant), 32'(e.grant));
    checkOutput("sb_busy", 32'(busy), 32'(e.busy));
    checkOutput("sb_done", 32'(dwell_done), 32'(e.done));
  endtask

  // Holds one input pattern for n cycles.
  task automatic holdCycles(input logic r, input logic [2:0] rq, input int n);
    for (int i = 0; i < n; i++) applyStimulus(r, rq, vals);
  endtask

  // Scenario sequence.
  initial begin
    vals = {16'h3333, 16'h2222, 16'h1111};
    m_show = 1'b0; m_cnt = 0; m_rr = 2'd2; m_owner = 2'd0;
    m_disp = 16'h0000; m_grant = 3'b000; m_done = 1'b0;
    done_count = 0;

    // Reset then a long idle stretch: nothing may be shown or pulse.
    holdCycles(1'b1, 3'b000, 2);
    checkOutput("rst_disp", 32'(disp_value), 32'h0000);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    done_count = 0;
    holdCycles(1'b0, 3'b000, 20);
    checkOutput("idle_no_done", 32'(done_count), 32'd0);

    // Single requester: repeated self re-grant, dwell_done every 4 cycles.
    done_count = 0;
    applyStimulus(1'b0, 3'b001, vals);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("single_disp", 32'(disp_value), 32'h1111);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 3'b001, vals);
      checkOutput("single_hold", 32'(grant), 32'h1);
    end
    checkOutput("single_pulses", 32'(done_count), 32'd3);
    holdCycles(1'b0, 3'b000, 4);
    checkOutput("single_idle", 32'(busy), 32'h0);

    // Rotation from reset: 001,010,100,001 with exactly 4 cycles each.
    holdCycles(1'b1, 3'b000, 2);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1'b0, 3'b111, vals);
      checkOutput("rot_grant", 32'(grant), 32'(3'b001 << (((c - 1) / 4) % 3)));
      checkOutput("rot_disp", 32'(disp_value), 32'(vals[16*(((c - 1) / 4) % 3) +: 16]));
    end
    holdCycles(1'b0, 3'b000, 3);

    // Early drop: owner value changes, then request drops mid-dwell.
    applyStimulus(1'b0, 3'b010, vals);
    checkOutput("drop_grant", 32'(grant), 32'h2);
    applyStimulus(1'b0, 3'b010, vals);
    applyStimulus(1'b0, 3'b010, {16'h3333, 16'hABCD, 16'h1111});
    checkOutput("track_disp", 32'(disp_value), 32'hABCD);
    applyStimulus(1'b0, 3'b000, {16'h3333, 16'h5555, 16'h1111});
    checkOutput("drop_hold", 32'(disp_value), 32'hABCD);
    checkOutput("drop_done", 32'(dwell_done), 32'h1);
    applyStimulus(1'b0, 3'b000, vals);
    checkOutput("drop_idle_disp", 32'(disp_value), 32'h0000);
    checkOutput("drop_idle_grant", 32'(grant), 32'h0);
    holdCycles(1'b0, 3'b000, 2);

    // Reset mid-dwell: cleared on the next edge, restart from requester 0.
    holdCycles(1'b0, 3'b010, 2);
    applyStimulus(1'b1, 3'b010, vals);
    checkOutput("midrst_grant", 32'(grant), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_done", 32'(dwell_done), 32'h0);
    applyStimulus(1'b0, 3'b111, vals);
    checkOutput("midrst_first", 32'(grant), 32'h1);
    holdCycles(1'b0, 3'b111, 5);
    holdCycles(1'b0, 3'b000, 6);

    // Urgent requester 0 arriving late in requester 1's dwell.
    holdCycles(1'b1, 3'b000, 2);
    holdCycles(1'b0, 3'b010, 3);
    applyStimulus(1'b0, 3'b011, vals);
`ifdef SEG_ARB_PREEMPT_EN
    checkOutput("pre_grant", 32'(grant), 32'h1);
    checkOutput("pre_no_done", 32'(dwell_done), 32'h0);
    checkOutput("pre_disp", 32'(disp_value), 32'h1111);
    applyStimulus(1'b0, 3'b011, vals);
    applyStimulus(1'b0, 3'b110, vals);
    applyStimulus(1'b0, 3'b110, vals);
    checkOutput("pre_hold", 32'(grant), 32'h1);
    checkOutput("pre_dwell_end", 32'(dwell_done), 32'h1);
    applyStimulus(1'b0, 3'b110, vals);
    checkOutput("pre_resume", 32'(grant), 32'h4);
`else
    checkOutput("wait_grant", 32'(grant), 32'h2);
    checkOutput("wait_done", 32'(dwell_done), 32'h1);
    applyStimulus(1'b0, 3'b011, vals);
    checkOutput("wait_next", 32'(grant), 32'h1);
    holdCycles(1'b0, 3'b110, 3);
    applyStimulus(1'b0, 3'b110, vals);
    checkOutput("wait_rotate", 32'(grant), 32'h2);
`endif
    holdCycles(1'b0, 3'b000, 6);

    // Random requests and values, checked only against the model.
    for (int i = 0; i < 60; i++) begin
      vals = {16'($urandom), 16'($urandom), 16'($urandom)};
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), vals);
    end
    vals = {16'h3333, 16'h2222, 16'h1111};
    holdCycles(1'b0, 3'b000, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
